// File: rtl/icache_way_array_if.sv
// rtl/icache_way_array_if.sv - lookup/write/flush bus between the ICache control FSM and the way array
interface icache_way_array_if #(
  parameter int INDEX_SIZE    = 6,
  parameter int WORD_OFF_SIZE = 4,
  parameter int TAG_SIZE      = 20,
  parameter int WAYS          = 2
);
  localparam int LINE_BITS = 32 * (2 ** WORD_OFF_SIZE);
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                  rd_en;
  logic [INDEX_SIZE-1:0] rd_index;
  logic [TAG_SIZE-1:0]   rd_tag;
  logic                  rsp_valid;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic [LINE_BITS-1:0]  rd_data;
  logic [WAY_BITS-1:0]   victim_way;
  logic                  wr_en;
  logic [INDEX_SIZE-1:0] wr_index;
  logic [WAY_BITS-1:0]   wr_way;
  logic [TAG_SIZE-1:0]   wr_tag;
  logic [LINE_BITS-1:0]  wr_data;
  logic                  wr_valid;
  logic                  inv_all;
  logic                  inv_busy;

  modport master (
    output rd_en, rd_index, rd_tag, wr_en, wr_index, wr_way, wr_tag, wr_data, wr_valid, inv_all,
    input  rsp_valid, hit, hit_way, rd_data, victim_way, inv_busy
  );

  modport slave (
    input  rd_en, rd_index, rd_tag, wr_en, wr_index, wr_way, wr_tag, wr_data, wr_valid, inv_all,
    output rsp_valid, hit, hit_way, rd_data, victim_way, inv_busy
  );
endinterface

// File: rtl/icache_way_array.sv
// rtl/icache_way_array.sv - N-way ICache tag/data/valid array with registered lookup and invalidate-all
module icache_way_array #(
  parameter int INDEX_SIZE    = 6,
  parameter int WORD_OFF_SIZE = 4,
  parameter int TAG_SIZE      = 20,
  parameter int WAYS          = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  icache_way_array_if.slave     bus
);
  localparam int SETS      = 2 ** INDEX_SIZE;
  localparam int LINE_BITS = 32 * (2 ** WORD_OFF_SIZE);
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [INDEX_SIZE-1:0] cnt_q, cnt_d;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAY_BITS-1:0]   ptr_q   [SETS];
  logic [WAY_BITS-1:0]   ptr_d   [SETS];
  logic [TAG_SIZE-1:0]   tag_mem  [WAYS][SETS];
  logic [LINE_BITS-1:0]  data_mem [WAYS][SETS];

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  hit_q, hit_d;
  logic [WAY_BITS-1:0]   hit_way_q, hit_way_d;
  logic [LINE_BITS-1:0]  rd_data_q, rd_data_d;
  logic [WAY_BITS-1:0]   victim_q, victim_d;

  logic                  lk_hit;
  logic [WAY_BITS-1:0]   lk_way;
  logic [LINE_BITS-1:0]  lk_data;
  logic [WAY_BITS-1:0]   lk_victim;
  logic                  wr_fire;
  logic [WAY_BITS-1:0]   next_ptr;

  // Descending scan so the lowest matching / lowest invalid way is the one left standing.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    lk_data   = '0;
    lk_victim = ptr_q[bus.rd_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[bus.rd_index][w] && (tag_mem[w][bus.rd_index] == bus.rd_tag)) begin
        lk_hit  = 1'b1;
        lk_way  = WAY_BITS'(w);
        lk_data = data_mem[w][bus.rd_index];
      end
      if (!valid_q[bus.rd_index][w]) begin
        lk_victim = WAY_BITS'(w);
      end
    end
  end

  assign wr_fire  = (state_q == IDLE) && !bus.inv_all && bus.wr_en;
  assign next_ptr = (WAYS == 1) ? '0 : WAY_BITS'(bus.wr_way + 1'b1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    hit_d       = hit_q;
    hit_way_d   = hit_way_q;
    rd_data_d   = rd_data_q;
    victim_d    = victim_q;
    case (state_q)
      IDLE: begin
        if (bus.inv_all) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          if (bus.rd_en) begin
            rsp_valid_d = 1'b1;
            hit_d       = lk_hit;
            hit_way_d   = lk_way;
            rd_data_d   = lk_data;
            victim_d    = lk_victim;
          end
          if (bus.wr_en) begin
            valid_d[bus.wr_index][bus.wr_way] = bus.wr_valid;
            if (bus.wr_valid) begin
              ptr_d[bus.wr_index] = next_ptr;
            end
          end
        end
      end
      FLUSH: begin
        valid_d[cnt_q] = '0;
        ptr_d[cnt_q]   = '0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == {INDEX_SIZE{1'b1}}) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      rd_data_q   <= '0;
      victim_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      hit_q       <= hit_d;
      hit_way_q   <= hit_way_d;
      rd_data_q   <= rd_data_d;
      victim_q    <= victim_d;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= valid_d[s];
        ptr_q[s]   <= ptr_d[s];
      end
    end
  end

  // Tag/data need no reset: valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      tag_mem[bus.wr_way][bus.wr_index]  <= bus.wr_tag;
      data_mem[bus.wr_way][bus.wr_index] <= bus.wr_data;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.hit        = hit_q;
  assign bus.hit_way    = hit_way_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.victim_way = victim_q;
  assign bus.inv_busy   = (state_q == FLUSH);
endmodule

// File: doc/icache_way_array.md
Name: icache_way_array

Overview:
- N-way set-associative storage array for the instruction cache: per-way tag, data-line and valid storage, plus per-set replacement state.
- Performs a registered lookup with tag compare, hit-way select and victim choice.
- Supports line fill, single-line invalidate, and a sequenced invalidate-all (cache-op / fence.i).
- Sits between the ICache control FSM and the AXI refill path; the control FSM owns miss handling.

Parameters:
- INDEX_SIZE, 6, set index width; SETS = 2**INDEX_SIZE.
- WORD_OFF_SIZE, 4, word offset width; LINE_BITS = 32 * 2**WORD_OFF_SIZE (512 by default).
- TAG_SIZE, 20, tag width; TAG_SIZE + INDEX_SIZE + WORD_OFF_SIZE + 2 must equal 32.
- WAYS, 2, associativity; legal values 1, 2, 4; WAY_BITS = max(1, log2(WAYS)).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_en  in  1  lookup request.
- rd_index  in  INDEX_SIZE  lookup set.
- rd_tag  in  TAG_SIZE  lookup tag to compare.
- rsp_valid  out  1  lookup result valid (one cycle after an accepted rd_en).
- hit  out  1  lookup hit.
- hit_way  out  WAY_BITS  way that hit.
- rd_data  out  LINE_BITS  line data of the hit way (0 on miss).
- victim_way  out  WAY_BITS  way to refill on a miss.
- wr_en  in  1  write request.
- wr_index  in  INDEX_SIZE  write set.
- wr_way  in  WAY_BITS  write way.
- wr_tag  in  TAG_SIZE  tag to store.
- wr_data  in  LINE_BITS  line data to store.
- wr_valid  in  1  valid bit to store; 1 = fill, 0 = single-line invalidate.
- inv_all  in  1  start invalidate-all (pulse).
- inv_busy  out  1  invalidate-all in progress.

Behaviour:
- Reset (async, active-high):
  - All valid bits and per-set round-robin pointers clear to 0; FSM goes to IDLE.
  - rsp_valid, hit, hit_way, rd_data, victim_way and inv_busy all read 0.
  - Tag and data storage are not reset.
- FSM IDLE:
  - rd_en and wr_en are accepted.
  - inv_all=1 moves to FLUSH and loads the set counter with 0; inv_busy=1 from the next cycle.
- FSM FLUSH:
  - Each cycle clears valid for all ways of set[counter] and resets that set's pointer to 0.
  - The counter increments; after clearing set SETS-1 the FSM returns to IDLE.
  - inv_busy is high for exactly SETS cycles.
  - rd_en and wr_en are ignored in FLUSH (rsp_valid=0); inv_all in FLUSH is ignored.
- Lookup latency is 1 cycle:
  - rd_en at edge T (IDLE) gives rsp_valid=1 during cycle T+1 with hit, hit_way, rd_data and victim_way.
  - Without rd_en, rsp_valid=0 and the other outputs hold their last values.
- Hit rule:
  - hit = OR over ways of (valid[w] & tag[w]==rd_tag), using the stored tag and valid.
  - If several ways match, the lowest-numbered way wins.
- Victim rule:
  - victim_way = lowest-numbered invalid way in the set; if all ways are valid, it is the set's round-robin pointer.
  - Victim is reported on every response, hit or miss.
- Write (IDLE, wr_en=1):
  - Stores tag, data and valid=wr_valid into (wr_index, wr_way) at the edge.
  - If wr_valid=1, pointer[wr_index] becomes (wr_way+1) mod WAYS; a wr_valid=0 write leaves the pointer unchanged.
- Read and write in the same cycle:
  - Same set: the lookup reports the pre-write contents (read-before-write); the write takes effect for lookups issued from the next cycle.
  - Different sets: the two operations are independent.
- inv_all together with rd_en/wr_en in IDLE: inv_all wins; the read and write are dropped.
- Reset asserted mid-FLUSH: immediate return to IDLE, all valid bits 0, inv_busy=0.
- WAYS=1: hit_way and victim_way are always 0; the pointer is unused.

Test Plan:
- Release reset; rd_en at index 5, tag 0x12345 -> next cycle rsp_valid=1, hit=0, victim_way=0, rd_data=0.
- Fill (5, way 0, tag 0x12345, data word i = i) -> lookup 0x12345 gives hit=1, hit_way=0, data match, victim_way=1; lookup tag 0x54321 gives hit=0, victim_way=1.
- Fill way 0 then way 1 of set 9 (WAYS=2) -> pointer=0, victim_way=0; refill way 0 -> victim_way=1; single-line invalidate of way 1 -> victim_way=1, and a lookup of the way-1 tag misses.
- Same-cycle rd_en and wr_en to set 3 with a new tag -> the response reports the old state (miss); a lookup on the following cycle hits.
- inv_all with several sets filled -> inv_busy high for 64 cycles, rd_en during that window gives rsp_valid=0; afterwards every lookup misses and victim_way=0.
- Assert reset at FLUSH cycle 20 -> inv_busy=0 immediately; after release a lookup of a previously filled line misses.
